// File: rtl/io_input_responder_pkg.sv
// Shared types for the user-input responder: FSM state encoding and the
// width of the data word handed to the register file.
package io_input_responder_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_RELEASE,
    WAIT_PRESS,
    HOLD
  } state_t;

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer plus counting debouncer for one push button.
// Produces a clean level and a one-clk pulse on each accepted 0->1 change.
module io_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // NOTE: state is written with non-blocking assignments so every flop
  // samples the pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      rise  <= 1'b0;
      // Any sample agreeing with the current level restarts the qualification run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        rise  <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_input_responder.sv
// Responder for the CPU's user-input instruction: stalls the CPU until a
// debounced button press, captures the switch word and releases the stall.
module io_input_responder
  import io_input_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int IN_W            = 14,
  parameter int SIGN_EXT        = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inop,
  input  logic              clk_state,
  input  logic              bt,
  input  logic [IN_W-1:0]   in,
  output logic [DATA_W-1:0] du,
  output logic              await,
  output logic              captured
);

  state_t            state;
  state_t            next_state;
  logic              capture_now;
  logic [IN_W-1:0]   in_meta;
  logic [IN_W-1:0]   in_sync;
  logic [DATA_W-1:0] in_ext;
  logic              btn_db;
  logic              btn_rise;
  logic              cs_prev;
  logic              cs_rise;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk  (clk),
    .reset(reset),
    .raw  (bt),
    .level(btn_db),
    .rise (btn_rise)
  );

  assign cs_rise = clk_state & ~cs_prev;

  always_comb begin
    if (SIGN_EXT != 0) begin
      in_ext = {{(DATA_W-IN_W){in_sync[IN_W-1]}}, in_sync};
    end else begin
      in_ext = {{(DATA_W-IN_W){1'b0}}, in_sync};
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    next_state  = state;
    capture_now = 1'b0;
    case (state)
      IDLE: begin
        if (inop) next_state = btn_db ? WAIT_RELEASE : WAIT_PRESS;
      end
      WAIT_RELEASE: begin
        if (!inop)        next_state = IDLE;
        else if (!btn_db) next_state = WAIT_PRESS;
      end
      WAIT_PRESS: begin
        // A withdrawn request beats a press arriving in the same clk.
        if (!inop) begin
          next_state = IDLE;
        end else if (btn_rise) begin
          next_state  = HOLD;
          capture_now = 1'b1;
        end
      end
      HOLD: begin
        if (cs_rise) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Stall is combinational so it is already high in the clk inop rises.
  assign await = inop & (state != HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      in_meta  <= '0;
      in_sync  <= '0;
      cs_prev  <= 1'b0;
      du       <= '0;
      captured <= 1'b0;
    end else begin
      state    <= next_state;
      in_meta  <= in;
      in_sync  <= in_meta;
      cs_prev  <= clk_state;
      captured <= capture_now;
      if (capture_now) du <= in_ext;
    end
  end

endmodule

// File: tb/tb_io_input_responder.sv
// Scoreboard bench for io_input_responder: sign- and zero-extending copies
// share stimulus; expected captures are queued and checked on each pulse.
module tb_io_input_responder;
  import io_input_responder_pkg::*;

  localparam int DB   = 4;
  localparam int IN_W = 14;

  logic              clk = 1'b0;
  logic              reset;
  logic              inop;
  logic              clk_state;
  logic              bt;
  logic [IN_W-1:0]   din;
  logic [DATA_W-1:0] du_s, du_z;
  logic              await_s, await_z;
  logic              cap_s, cap_z;

  int n_checks = 0;
  int n_fail   = 0;
  int caps_s   = 0;
  int caps_z   = 0;
  int exp_caps = 0;
  logic [DATA_W-1:0] q_s[$];
  logic [DATA_W-1:0] q_z[$];

  always #5 clk = ~clk;

  io_input_responder #(.DEBOUNCE_CYCLES(DB), .IN_W(IN_W), .SIGN_EXT(1)) dut_s (
    .clk(clk), .reset(reset), .inop(inop), .clk_state(clk_state), .bt(bt),
    .in(din), .du(du_s), .await(await_s), .captured(cap_s)
  );

  io_input_responder #(.DEBOUNCE_CYCLES(DB), .IN_W(IN_W), .SIGN_EXT(0)) dut_z (
    .clk(clk), .reset(reset), .inop(inop), .clk_state(clk_state), .bt(bt),
    .in(din), .du(du_z), .await(await_z), .captured(cap_z)
  );

  function automatic logic [31:0] sext(input logic [IN_W-1:0] v);
    return {{(32-IN_W){v[IN_W-1]}}, v};
  endfunction

  function automatic logic [31:0] zext(input logic [IN_W-1:0] v);
    return {{(32-IN_W){1'b0}}, v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever either DUT reports a capture.
  always @(negedge clk) begin
    if (cap_s) begin
      caps_s++;
      if (q_s.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_capture_s: du 0x%08h with empty queue", du_s);
      end else begin
        check("du_s_capture", du_s, q_s.pop_front());
      end
    end
    if (cap_z) begin
      caps_z++;
      if (q_z.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_capture_z: du 0x%08h with empty queue", du_z);
      end else begin
        check("du_z_capture", du_z, q_z.pop_front());
      end
    end
  end

  task automatic expect_capture(input logic [IN_W-1:0] v);
    q_s.push_back(sext(v));
    q_z.push_back(zext(v));
    exp_caps++;
  endtask

  // One complete input instruction; assumes the button is released.
  task automatic press_and_capture(input logic [IN_W-1:0] v);
    din  = v;
    inop = 1'b1;
    tick(3);
    check("await_pending", 32'(await_s), 32'd1);
    check("state_wait_press", 32'(dut_s.state), 32'(WAIT_PRESS));
    expect_capture(v);
    bt = 1'b1;
    tick(DB + 2);
    check("await_before_accept", 32'(await_s), 32'd1);
    tick(1);
    check("await_after_accept_s", 32'(await_s), 32'd0);
    check("await_after_accept_z", 32'(await_z), 32'd0);
    tick(3);
    bt = 1'b0;
    tick(8);
    check("state_hold", 32'(dut_s.state), 32'(HOLD));
    check("caps_after_press", 32'(caps_s), 32'(exp_caps));
  endtask

  // CPU consumes the data with a clk_state rise; keep=1 models back-to-back inputs.
  task automatic end_instruction(input logic keep);
    check("await_in_hold", 32'(await_s), 32'd0);
    inop      = keep;
    clk_state = 1'b1;
    tick(1);
    check("state_idle_after_cs", 32'(dut_s.state), 32'(IDLE));
    check("await_after_cs", 32'(await_s), 32'(keep));
    clk_state = 1'b0;
    tick(1);
  endtask

  initial begin
    reset = 1'b1; inop = 1'b0; clk_state = 1'b0; bt = 1'b0; din = '0;
    tick(3);
    check("reset_du_s", du_s, 32'h0);
    check("reset_captured", 32'(cap_s), 32'd0);
    check("reset_await", 32'(await_s), 32'd0);
    reset = 1'b0;
    tick(2);

    // Basic capture and extension vectors.
    press_and_capture(14'h0005);
    check("du_0005", du_s, 32'h00000005);
    end_instruction(1'b0);
    press_and_capture(14'h3FFF);
    check("du_3fff_sext", du_s, 32'hFFFFFFFF);
    check("du_3fff_zext", du_z, 32'h00003FFF);
    end_instruction(1'b0);
    press_and_capture(14'h2000);
    check("du_2000_sext", du_s, 32'hFFFFE000);
    check("du_2000_zext", du_z, 32'h00002000);
    end_instruction(1'b0);

    // Bouncing button: runs of 2 samples never qualify, settled high does once.
    din  = 14'h00AA;
    inop = 1'b1;
    tick(3);
    expect_capture(14'h00AA);
    for (int i = 0; i < 6; i++) begin
      bt = (i % 2 == 0);
      tick(2);
    end
    bt = 1'b1;
    tick(3);
    check("no_capture_while_bouncing", 32'(caps_s), 32'(exp_caps - 1));
    check("await_while_bouncing", 32'(await_s), 32'd1);
    tick(8);
    check("one_capture_after_bounce", 32'(caps_s), 32'(exp_caps));
    end_instruction(1'b0);

    // Button still held from the previous input must not satisfy a new request.
    din  = 14'h0123;
    inop = 1'b1;
    tick(3);
    check("state_wait_release", 32'(dut_s.state), 32'(WAIT_RELEASE));
    tick(5);
    check("no_capture_held", 32'(caps_s), 32'(exp_caps));
    check("await_held", 32'(await_s), 32'd1);
    bt = 1'b0;
    tick(8);
    press_and_capture(14'h2456);
    check("du_2456_sext", du_s, 32'hFFFFE456);

    // Back-to-back input instructions.
    end_instruction(1'b1);
    press_and_capture(14'h0777);
    check("du_0777", du_s, 32'h00000777);

    // Press accepted in the same clk the request is withdrawn: no capture.
    end_instruction(1'b1);
    tick(2);
    check("state_wait_press_2", 32'(dut_s.state), 32'(WAIT_PRESS));
    bt = 1'b1;
    tick(DB + 2);
    inop = 1'b0;
    tick(1);
    check("withdraw_state", 32'(dut_s.state), 32'(IDLE));
    check("withdraw_await", 32'(await_s), 32'd0);
    tick(3);
    check("withdraw_no_capture", 32'(caps_s), 32'(exp_caps));
    check("withdraw_du_kept", du_s, 32'h00000777);
    bt = 1'b0;
    tick(8);

    // Reset in the middle of a request.
    inop = 1'b1;
    tick(3);
    check("state_wait_press_3", 32'(dut_s.state), 32'(WAIT_PRESS));
    reset = 1'b1;
    tick(1);
    check("reset_mid_state", 32'(dut_s.state), 32'(IDLE));
    check("reset_mid_du_s", du_s, 32'h0);
    check("reset_mid_du_z", du_z, 32'h0);
    reset = 1'b0;
    inop  = 1'b0;
    tick(1);
    check("reset_mid_await", 32'(await_s), 32'd0);

    tick(5);
    check("queue_s_drained", 32'(q_s.size()), 32'd0);
    check("queue_z_drained", 32'(q_z.size()), 32'd0);
    check("caps_s_total", 32'(caps_s), 32'(exp_caps));
    check("caps_z_total", 32'(caps_z), 32'(exp_caps));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
